// File: rtl/loadip_multibank_buffer_if.sv
// Handshake/data bundle between a load source (master) and the multibank buffer (slave).
// Port names keep their i_/o_ direction as seen from the buffer.
interface loadip_multibank_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 2
);
  logic [NUM_BANKS-1:0]  o_wr_ready;
  logic [NUM_BANKS-1:0]  i_wr_activate;
  logic [15:0]           o_wr_fifo_size;
  logic                  i_wstrobe;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  o_starved;
  logic                  i_rd_activate;
  logic                  o_rd_ready;
  logic [15:0]           o_rd_cnt;
  logic                  i_rstrobe;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_inactive;
  logic                  i_err_clr;
  logic [2:0]            o_err;

  modport slave (
    output o_wr_ready, o_wr_fifo_size, o_starved, o_rd_ready, o_rd_cnt, o_rdata, o_inactive, o_err,
    input  i_wr_activate, i_wstrobe, i_wdata, i_rd_activate, i_rstrobe, i_err_clr
  );

  modport master (
    input  o_wr_ready, o_wr_fifo_size, o_starved, o_rd_ready, o_rd_cnt, o_rdata, o_inactive, o_err,
    output i_wr_activate, i_wstrobe, i_wdata, i_rd_activate, i_rstrobe, i_err_clr
  );
endinterface

// File: rtl/loadip_multibank_buffer.sv
// N-bank round-robin load buffer: writer fills banks in order, reader drains committed banks in
// the same order with first-word-fall-through data and sticky error flags.
module loadip_multibank_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BANKS  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  loadip_multibank_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_e;

  bank_state_e            state_q [NUM_BANKS];
  bank_state_e            state_d [NUM_BANKS];
  logic [CW-1:0]          cnt_q   [NUM_BANKS];
  logic [CW-1:0]          cnt_d   [NUM_BANKS];
  logic [BW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_BANKS-1:0]   wr_act_q, wr_rise, wr_ready_q, wr_ready_d;
  logic                   rd_act_q, rd_rise, rd_ready_q, rd_ready_d;
  logic [15:0]            rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]          rd_idx_q, rd_idx_d, rd_idx_nxt;
  logic                   starved_q, starved_d, inactive_q, inactive_d;
  logic [2:0]             err_q, err_d;
  logic                   wr_open, rd_open;
  logic                   mem_we, rd_load;
  logic [BW+ADDR_WIDTH-1:0] mem_waddr, rd_raddr;
  logic [NUM_BANKS-1:0]   bank_empty_d, bank_held_d;
  logic [DATA_WIDTH-1:0]  mem [NUM_BANKS*DEPTH];
  logic [DATA_WIDTH-1:0]  rdata_q;

  assign wr_rise    = bus.i_wr_activate & ~wr_act_q;
  assign rd_rise    = bus.i_rd_activate & ~rd_act_q;
  assign rd_idx_nxt = rd_idx_q + 1'b1;
  assign wr_open    = (state_q[wr_ptr_q] == B_FILLING) && bus.i_wr_activate[wr_ptr_q];
  assign rd_open    = (state_q[rd_ptr_q] == B_READING) && bus.i_rd_activate;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_idx_d  = rd_idx_q;
    err_d     = bus.i_err_clr ? 3'b000 : err_q;
    mem_we    = 1'b0;
    mem_waddr = {wr_ptr_q, cnt_q[wr_ptr_q][ADDR_WIDTH-1:0]};
    rd_load   = 1'b0;
    rd_raddr  = {rd_ptr_q, rd_idx_nxt[ADDR_WIDTH-1:0]};

    // A claim is only honoured when exactly the offered bit rises and nothing else is held.
    if (wr_rise != '0) begin
      if (wr_rise == wr_ready_q && bus.i_wr_activate == wr_ready_q) state_d[wr_ptr_q] = B_FILLING;
      else err_d[2] = 1'b1;
    end

    if (bus.i_wstrobe) begin
      if (wr_open && cnt_q[wr_ptr_q] < DEPTH_C) begin
        mem_we             = 1'b1;
        cnt_d[wr_ptr_q]    = cnt_q[wr_ptr_q] + 1'b1;
      end else begin
        err_d[0] = 1'b1;
      end
    end

    if (state_q[wr_ptr_q] == B_FILLING && !bus.i_wr_activate[wr_ptr_q]) begin
      if (cnt_q[wr_ptr_q] != '0) begin
        state_d[wr_ptr_q] = B_FULL;
        wr_ptr_d          = (wr_ptr_q == LAST_BANK) ? '0 : wr_ptr_q + 1'b1;
      end else begin
        state_d[wr_ptr_q] = B_EMPTY;
      end
    end

    if (rd_rise && rd_ready_q) begin
      state_d[rd_ptr_q] = B_READING;
      rd_idx_d          = '0;
      rd_load           = 1'b1;
      rd_raddr          = {rd_ptr_q, {ADDR_WIDTH{1'b0}}};
    end else if (state_q[rd_ptr_q] == B_READING && !bus.i_rd_activate) begin
      state_d[rd_ptr_q] = B_EMPTY;
      cnt_d[rd_ptr_q]   = '0;
      rd_ptr_d          = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + 1'b1;
    end

    // The last word stays on o_rdata after it is consumed; no read past the bank end.
    if (bus.i_rstrobe) begin
      if (rd_open && rd_idx_q < cnt_q[rd_ptr_q]) begin
        rd_idx_d = rd_idx_nxt;
        rd_load  = (rd_idx_nxt < cnt_q[rd_ptr_q]);
      end else begin
        err_d[1] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : gen_bank
    assign bank_empty_d[gi] = (state_d[gi] == B_EMPTY);
    assign bank_held_d[gi]  = (state_d[gi] == B_FULL) || (state_d[gi] == B_READING);
  end

  always_comb begin
    wr_ready_d = (state_d[wr_ptr_d] == B_EMPTY) ? (NUM_BANKS'(1) << wr_ptr_d) : '0;
    rd_ready_d = (state_d[rd_ptr_d] == B_FULL) && !bus.i_rd_activate;
    rd_cnt_d   = bank_held_d[rd_ptr_d] ? 16'(cnt_d[rd_ptr_d]) : 16'd0;
    starved_d  = ~|bank_held_d;
    inactive_d = &bank_empty_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= B_EMPTY;
        cnt_q[i]   <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_act_q   <= '0;
      rd_act_q   <= 1'b0;
      wr_ready_q <= NUM_BANKS'(1);
      rd_ready_q <= 1'b0;
      rd_cnt_q   <= '0;
      rd_idx_q   <= '0;
      starved_q  <= 1'b1;
      inactive_q <= 1'b1;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_act_q   <= bus.i_wr_activate;
      rd_act_q   <= bus.i_rd_activate;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_idx_q   <= rd_idx_d;
      starved_q  <= starved_d;
      inactive_q <= inactive_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= bus.i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     rdata_q <= '0;
    else if (rd_load) rdata_q <= mem[rd_raddr];
  end

  assign bus.o_wr_ready     = wr_ready_q;
  assign bus.o_wr_fifo_size = 16'(DEPTH);
  assign bus.o_starved      = starved_q;
  assign bus.o_rd_ready     = rd_ready_q;
  assign bus.o_rd_cnt       = rd_cnt_q;
  assign bus.o_rdata        = rdata_q;
  assign bus.o_inactive     = inactive_q;
  assign bus.o_err          = err_q;
endmodule
